sram_recorder: RTL and testbench
================================

Name: sram_recorder

Overview:
Record-side counterpart of the SRAM playback path. Deserialises the left-channel 16-bit ADC sample from the codec's I2S stream (BCLK, ADCLRCK, ADCDAT) and writes one sample per LRCK frame into external SRAM at consecutive addresses. Supports record, pause and stop, and reports the end-of-take address that the playback block consumes as its end address. Sits between the codec ADC pins and the SRAM arbiter; its status outputs feed the LCD display block.

Parameters:
DATA_W, 16, sample and SRAM data width
ADDR_W, 20, SRAM address width
MAX_ADDR, 20'hFFFFF, last writable SRAM address

Ports:
i_bclk  in  1  codec bit clock; sole clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  record mode selected (switch); low forces IDLE
i_record  in  1  one-cycle pulse from debounced KEY; start/pause/resume toggle
i_stop  in  1  one-cycle pulse from debounced KEY
i_ADCLRCK  in  1  codec ADC LR clock, synchronous to i_bclk
i_ADCDAT  in  1  codec ADC serial data, MSB first
o_addr  out  ADDR_W  SRAM write address
o_SRAM_DQ  out  DATA_W  SRAM write data; top level tristates it when o_SRAM_WE_N=1
o_SRAM_WE_N  out  1  SRAM write strobe, active low
o_end_addr  out  ADDR_W  samples written in the current take (next free address)
o_rec_n  out  1  low while in REC
o_full  out  1  high once the take stopped on reaching MAX_ADDR
o_state  out  4  IDLE 4'b1000, STOP 4'b0000, REC 4'b0101, PAUSE 4'b0110 (bit2 = write mode)

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_state 4'b1000, o_addr 0, o_SRAM_DQ 0, o_SRAM_WE_N 1, o_end_addr 0, o_rec_n 1, o_full 0, shift register and bit counter cleared. Reset mid-write deasserts WE_N immediately.
- Capture: LRCK sampled each posedge i_bclk. Falling edge (prev 1, now 0) detected at cycle C. I2S one-bit delay: bits are shifted in MSB-first at posedges C+2 .. C+17. Sample is valid in cycle C+18. Right-channel half (LRCK high) is ignored. A new falling edge before 16 bits are captured aborts the partial sample and restarts at bit 15.
- Write: in the valid cycle, if state==REC, latch the sample into o_SRAM_DQ with o_addr unchanged. In the next cycle, drive o_SRAM_WE_N=0 for exactly one cycle. In the cycle after that, set WE_N=1, o_addr+1 and o_end_addr = old o_addr+1. Data and address are stable across the WE_N low cycle. If state is not REC in the valid cycle, the sample is discarded and no write is issued.
- FSM, evaluated every cycle. Priority: !i_enable > i_stop > i_record.
  - IDLE: o_addr held at 0. i_enable -> STOP.
  - STOP: !i_enable -> IDLE. i_record -> REC; o_addr 0, o_end_addr 0, o_full 0 (new take overwrites the old one).
  - REC: !i_enable -> IDLE. i_stop -> STOP. i_record -> PAUSE. A write completing at o_addr==MAX_ADDR -> STOP with o_full=1 and o_end_addr=MAX_ADDR+1 saturated to MAX_ADDR. No wrap-around.
  - PAUSE: !i_enable -> IDLE. i_stop -> STOP. i_record -> REC; address continues from where it paused.
- A write strobe already in flight, i.e. the sample was accepted while in REC, always completes even if the state leaves REC during it. Address and end-address update normally.
- o_end_addr holds its value through STOP, PAUSE and IDLE until the next take starts, so playback can use it.
- o_rec_n = (state != REC), registered with the state.

Decomposition:
- Package audio_pkg: state enum {IDLE, STOP, REC, PAUSE}, the o_state encodings above, DATA_W/ADDR_W constants shared with the reader.
- Sub-module i2s_rx_left: LRCK edge detect, bit counter, shift register. Outputs a 16-bit sample and a one-cycle valid. The FSM and write sequencer stay in sram_recorder.

Test Plan:
- Reset, then i_enable=1 -> o_state 1000 then 0000; WE_N stays 1; all outputs at reset values.
- STOP, i_record pulse, then frames with left samples 16'h8001, 16'h1234 -> WE_N low once per frame; SRAM gets addr0=8001 and addr1=1234; o_end_addr=2; o_rec_n=0.
- REC, i_record pulse mid-capture of a frame -> that sample is not written; PAUSE (0110); resume pulse -> next sample written at the following address with no gap.
- i_stop and i_record pulsed in the same cycle during REC -> STOP wins; o_end_addr retained; a new i_record pulse restarts at addr 0 and o_end_addr becomes 0.
- Set MAX_ADDR=3 and record 5 frames -> exactly 4 writes (addr 0..3); then STOP with o_full=1 and o_end_addr=3; no write to addr 0.
- Assert i_rst_n low during the WE_N-low cycle -> WE_N=1 immediately and all outputs return to reset values.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the SRAM record/playback audio path.
package audio_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 20;

  // The encodings are the o_state values the LCD block decodes; bit 2 marks write mode.
  typedef enum logic [3:0] {
    StIdle  = 4'b1000,
    StStop  = 4'b0000,
    StRec   = 4'b0101,
    StPause = 4'b0110
  } state_e;

endpackage

// File: rtl/sram_recorder_if.sv
// SRAM write bus between the recorder and the SRAM arbiter.
interface sram_recorder_if;
  import audio_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sram_dq;
  logic              sram_we_n;

  modport master (output addr, sram_dq, sram_we_n);
  modport slave  (input  addr, sram_dq, sram_we_n);
endinterface

// File: rtl/sram_recorder_i2s_rx.sv
// Left-channel I2S receiver: LRCK falling-edge detect, one-bit delay, 16-bit MSB-first shift.
module i2s_rx_left
  import audio_pkg::*;
(
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_ADCLRCK,
  input  logic              i_ADCDAT,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_valid
);

  // cnt: 17 = skip the I2S delay bit, 16..1 = bits still to shift, 0 = idle
  localparam logic [4:0] CntDelay = 5'd17;

  logic              lrck_q;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              last_q, last_d;
  logic              valid_q;
  logic              fall;

  assign fall = lrck_q & ~i_ADCLRCK;

  // Next-state: a new falling edge always restarts capture at bit 15.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    last_d  = 1'b0;
    if (fall) begin
      cnt_d = CntDelay;
    end else if (cnt_q == CntDelay) begin
      cnt_d = 5'd16;
    end else if (cnt_q != 5'd0) begin
      shift_d = {shift_q[DATA_W-2:0], i_ADCDAT};
      cnt_d   = cnt_q - 5'd1;
      last_d  = (cnt_q == 5'd1);
    end
  end

  // Capture registers; valid lags the last shift by one cycle.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_q  <= 1'b0;
      cnt_q   <= 5'd0;
      shift_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lrck_q  <= i_ADCLRCK;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      valid_q <= last_q;
    end
  end

  assign o_sample = shift_q;
  assign o_valid  = valid_q;

endmodule

// File: rtl/sram_recorder.sv
// Records left-channel ADC samples into consecutive SRAM addresses with record/pause/stop.
module sram_recorder
  import audio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic                i_bclk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_record,
  input  logic                i_stop,
  input  logic                i_ADCLRCK,
  input  logic                i_ADCDAT,
  sram_recorder_if.master     sram,
  output logic [ADDR_W-1:0]   o_end_addr,
  output logic                o_rec_n,
  output logic                o_full,
  output logic [3:0]          o_state
);

  logic [DATA_W-1:0] sample;
  logic              sample_valid;

  i2s_rx_left u_rx (
    .i_bclk    (i_bclk),
    .i_rst_n   (i_rst_n),
    .i_ADCLRCK (i_ADCLRCK),
    .i_ADCDAT  (i_ADCDAT),
    .o_sample  (sample),
    .o_valid   (sample_valid)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic              we_n_q, we_n_d;
  logic              full_q, full_d;
  logic              wr_done, full_hit, take_start;

  // WE_N is low for exactly one cycle, so the write completes at the following edge.
  assign wr_done    = ~we_n_q;
  assign full_hit   = wr_done && (addr_q == MAX_ADDR);
  assign take_start = (state_q == StStop) && i_enable && i_record;

  // State register.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next state; priority !i_enable > i_stop > full > i_record.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_enable) state_d = StStop;
      StStop: begin
        if (!i_enable)     state_d = StIdle;
        else if (i_record) state_d = StRec;
      end
      StRec: begin
        if (!i_enable)     state_d = StIdle;
        else if (i_stop)   state_d = StStop;
        else if (full_hit) state_d = StStop;
        else if (i_record) state_d = StPause;
      end
      StPause: begin
        if (!i_enable)     state_d = StIdle;
        else if (i_stop)   state_d = StStop;
        else if (full_hit) state_d = StStop;
        else if (i_record) state_d = StRec;
      end
      default: state_d = StIdle;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    o_state = state_q;
    o_rec_n = (state_q != StRec);
  end

  // Write sequencer: latch in the valid cycle, strobe next, then advance the address.
  // An in-flight strobe finishes regardless of state changes.
  always_comb begin
    dq_d   = dq_q;
    we_n_d = 1'b1;
    addr_d = addr_q;
    end_d  = end_q;
    full_d = full_q;
    if (sample_valid && (state_q == StRec)) begin
      dq_d   = sample;
      we_n_d = 1'b0;
    end
    if (wr_done) begin
      if (full_hit) begin
        end_d  = MAX_ADDR;
        full_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
        end_d  = addr_q + 1'b1;
      end
    end
    if (take_start) begin
      addr_d = '0;
      end_d  = '0;
      full_d = 1'b0;
    end else if ((state_q == StIdle) && !wr_done) begin
      addr_d = '0;
    end
  end

  // Datapath registers; reset releases the write strobe immediately.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q <= '0;
      end_q  <= '0;
      dq_q   <= '0;
      we_n_q <= 1'b1;
      full_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      end_q  <= end_d;
      dq_q   <= dq_d;
      we_n_q <= we_n_d;
      full_q <= full_d;
    end
  end

  assign sram.addr      = addr_q;
  assign sram.sram_dq   = dq_q;
  assign sram.sram_we_n = we_n_q;
  assign o_end_addr     = end_q;
  assign o_full         = full_q;

endmodule

// File: tb/tb_sram_recorder.sv
// Directed bench for sram_recorder with a small SRAM write model.
module tb_sram_recorder;

  logic        clk = 1'b0;
  logic        rst_n, en, rec, stp, lrck, dat;
  logic [19:0] end_addr;
  logic        rec_n, full;
  logic [3:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  logic [15:0] mem [0:15];

  sram_recorder_if sram_bus ();

  sram_recorder #(.MAX_ADDR(20'd3)) dut (
    .i_bclk     (clk),
    .i_rst_n    (rst_n),
    .i_enable   (en),
    .i_record   (rec),
    .i_stop     (stp),
    .i_ADCLRCK  (lrck),
    .i_ADCDAT   (dat),
    .sram       (sram_bus.master),
    .o_end_addr (end_addr),
    .o_rec_n    (rec_n),
    .o_full     (full),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  // SRAM model: capture on the WE_N-low cycle.
  always @(negedge clk) begin
    if (sram_bus.sram_we_n === 1'b0) begin
      mem[sram_bus.addr[3:0]] <= sram_bus.sram_dq;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Slot k of a 40-cycle frame: LRCK low for 20, delay bit at slot 1, MSB at slot 2.
  task automatic drive_slot(input int k, input logic [15:0] s);
    lrck = (k < 20) ? 1'b0 : 1'b1;
    dat  = (k >= 2 && k <= 17) ? s[17-k] : 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] s, input int pulse_at);
    for (int k = 0; k < 40; k++) begin
      tick();
      drive_slot(k, s);
      rec = (k == pulse_at);
    end
    tick();
    rec = 1'b0;
  endtask

  task automatic pulse_rec();
    rec = 1'b1;
    tick();
    rec = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'h8);
    check({tag, "_addr"}, 32'(sram_bus.addr), 0);
    check({tag, "_dq"}, 32'(sram_bus.sram_dq), 0);
    check({tag, "_we_n"}, 32'(sram_bus.sram_we_n), 1);
    check({tag, "_end"}, 32'(end_addr), 0);
    check({tag, "_rec_n"}, 32'(rec_n), 1);
    check({tag, "_full"}, 32'(full), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    logic seen;
    rst_n = 1'b0; en = 1'b0; rec = 1'b0; stp = 1'b0; lrck = 1'b1; dat = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    check("idle_state", 32'(state), 32'h8);
    en = 1'b1;
    tick();
    check("stop_state", 32'(state), 32'h0);
    check("stop_we_n", 32'(sram_bus.sram_we_n), 1);

    // Basic take: two frames at addresses 0 and 1.
    pulse_rec();
    check("rec_state", 32'(state), 32'h5);
    check("rec_n_low", 32'(rec_n), 0);
    send_frame(16'h8001, -1);
    send_frame(16'h1234, -1);
    check("two_writes", 32'(wr_cnt), 2);
    check("mem0", 32'(mem[0]), 32'h8001);
    check("mem1", 32'(mem[1]), 32'h1234);
    check("end_addr2", 32'(end_addr), 2);
    check("rec_n_still", 32'(rec_n), 0);

    // Pause mid-capture drops that sample; resume continues without a gap.
    send_frame(16'hDEAD, 8);
    check("pause_state", 32'(state), 32'h6);
    check("pause_no_write", 32'(wr_cnt), 2);
    check("pause_end", 32'(end_addr), 2);
    pulse_rec();
    check("resume_state", 32'(state), 32'h5);
    send_frame(16'hBEEF, -1);
    check("resume_write", 32'(wr_cnt), 3);
    check("mem2", 32'(mem[2]), 32'hBEEF);
    check("end_addr3", 32'(end_addr), 3);

    // Stop and record together: stop wins, end address retained, next take restarts.
    stp = 1'b1; rec = 1'b1;
    tick();
    stp = 1'b0; rec = 1'b0;
    check("stop_wins", 32'(state), 32'h0);
    check("end_kept", 32'(end_addr), 3);
    check("rec_n_stop", 32'(rec_n), 1);
    pulse_rec();
    check("restart_state", 32'(state), 32'h5);
    check("restart_end", 32'(end_addr), 0);
    check("restart_addr", 32'(sram_bus.addr), 0);
    send_frame(16'h0F0F, -1);
    check("restart_mem0", 32'(mem[0]), 32'h0F0F);
    check("restart_end1", 32'(end_addr), 1);

    // Fill to MAX_ADDR=3: four writes, then STOP with full, fifth frame dropped.
    stp = 1'b1;
    tick();
    stp = 1'b0;
    pulse_rec();
    base = wr_cnt;
    send_frame(16'hA000, -1);
    send_frame(16'hA001, -1);
    send_frame(16'hA002, -1);
    send_frame(16'hA003, -1);
    send_frame(16'hA004, -1);
    check("full_writes", 32'(wr_cnt - base), 4);
    check("full_mem0", 32'(mem[0]), 32'hA000);
    check("full_mem3", 32'(mem[3]), 32'hA003);
    check("full_state", 32'(state), 32'h0);
    check("full_flag", 32'(full), 1);
    check("full_end", 32'(end_addr), 3);

    // Reset asserted during the WE_N-low cycle.
    pulse_rec();
    check("full_cleared", 32'(full), 0);
    base = wr_cnt;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      drive_slot(k, 16'h5A5A);
      @(posedge clk);
      #1;
      if (!seen && sram_bus.sram_we_n === 1'b0) begin
        seen = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwr");
      end
    end
    check("we_low_seen", 32'(seen), 1);
    tick();
    check("midwr_no_write", 32'(wr_cnt - base), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
